// File: rtl/stack_param.sv
// stack_param: parametrised LIFO with count, top peek, push+pop replace, clear and error pulses.
// Optional high-water-mark port/register enabled by defining STACK_HWM_EN.
module stack_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
`ifdef STACK_HWM_EN
   ,
   output logic [CW-1:0]    hwm
`endif
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic [AW-1:0]    top_idx, waddr;
   logic             psh, pp, repl, we;

   assign empty   = count_q == '0;
   assign full    = count_q == CW'(DEPTH);
   // count-1 always fits in AW bits when non-empty, so modular AW-bit math is exact
   assign top_idx = count_q[AW-1:0] - AW'(1);
   assign top     = empty ? '0 : mem_q[top_idx];

   assign repl = push & pop & ~empty;
   assign psh  = push & ~full & (~pop | empty);
   assign pp   = pop & ~push & ~empty;
   assign we   = psh | repl;
   assign waddr = repl ? top_idx : count_q[AW-1:0];

   always_comb begin
      count_d    = psh ? count_q + CW'(1) : pp ? count_q - CW'(1) : count_q;
      data_out_d = (pp | repl) ? top : data_out_q;
      ovf_d      = push & ~pop & full;
      unf_d      = pop & empty;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q    <= '0;
         data_out_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else if (clear) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q    <= count_d;
         data_out_q <= data_out_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // storage is never scrubbed; reset and clear only discard it through count
   always_ff @(posedge clk) begin
      if (rst && !clear && we) mem_q[waddr] <= data_in;
   end

`ifdef STACK_HWM_EN
   logic [CW-1:0] hwm_q;
   always_ff @(posedge clk) begin
      if (!rst || clear) hwm_q <= '0;
      else if (count_d > hwm_q) hwm_q <= count_d;
   end
   assign hwm = hwm_q;
`endif

   assign count     = count_q;
   assign data_out  = data_out_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
endmodule

// File: tb/tb_stack_param.sv
// tb_stack_param: directed test-plan steps plus random traffic, checked against a queue-based LIFO model.
module tb_stack_param;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int CW = $clog2(D+1);

   logic clk = 0, rst = 0, push = 0, pop = 0, clear = 0;
   logic [W-1:0]  data_in = '0;
   logic [W-1:0]  data_out, top;
   logic [CW-1:0] count;
   logic empty, full, overflow, underflow;
`ifdef STACK_HWM_EN
   logic [CW-1:0] hwm;
`endif

   stack_param #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear),
      .data_in(data_in), .data_out(data_out), .top(top), .count(count),
      .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
`ifdef STACK_HWM_EN
      , .hwm(hwm)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [W-1:0] mq[$];
   logic [W-1:0] m_dout = '0;
   bit m_ovf = 0, m_unf = 0;
   int m_hwm = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(bit pu, bit po, bit cl, bit r, logic [W-1:0] d);
      if (!r) begin
         mq = {}; m_dout = '0; m_ovf = 0; m_unf = 0; m_hwm = 0;
      end else if (cl) begin
         mq = {}; m_ovf = 0; m_unf = 0; m_hwm = 0;
      end else begin
         m_ovf = 0; m_unf = 0;
         if (pu && po) begin
            if (mq.size() > 0) begin
               m_dout = mq[mq.size()-1];
               mq[mq.size()-1] = d;
            end else begin
               mq.push_back(d);
               m_unf = 1;
            end
         end else if (pu) begin
            if (mq.size() == D) m_ovf = 1;
            else mq.push_back(d);
         end else if (po) begin
            if (mq.size() == 0) m_unf = 1;
            else m_dout = mq.pop_back();
         end
         if (mq.size() > m_hwm) m_hwm = mq.size();
      end
   endtask

   task automatic step(bit pu, bit po, bit cl, bit r, logic [W-1:0] d);
      logic [W-1:0] et;
      push = pu; pop = po; clear = cl; rst = r; data_in = d;
      @(posedge clk); #1;
      model(pu, po, cl, r, d);
      et = mq.size() > 0 ? mq[mq.size()-1] : '0;
      chk("count", 32'(count), 32'(mq.size()));
      chk("top", 32'(top), 32'(et));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == D));
      chk("data_out", 32'(data_out), 32'(m_dout));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef STACK_HWM_EN
      chk("hwm", 32'(hwm), 32'(m_hwm));
`endif
   endtask

   initial begin
      int pbias;
      step(0, 0, 0, 0, 8'h00);
      chk("reset_data_out", 32'(data_out), 32'h0);
      chk("reset_empty", 32'(empty), 32'h1);
      step(1, 0, 0, 1, 8'h03);
      chk("push03_top", 32'(top), 32'h03);
      step(0, 1, 0, 1, 8'h00);
      chk("pop03_data_out", 32'(data_out), 32'h03);
      for (int i = 1; i <= 10; i++) step(1, 0, 0, 1, W'(i));
      chk("fill_top", 32'(top), 32'h08);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 8'h00);
      chk("drain_hold", 32'(data_out), 32'h01);
      step(1, 0, 0, 1, 8'hA1);
      step(1, 0, 0, 1, 8'hB2);
      step(1, 1, 0, 1, 8'hC3);
      chk("replace_dout", 32'(data_out), 32'hB2);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 1, W'(8'h40 + i));
      step(1, 1, 0, 1, 8'h99);
      chk("replace_full_ovf", 32'(overflow), 32'h0);
      step(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 1, W'(8'h10 + i));
      step(1, 0, 1, 1, 8'h77);
      chk("clear_count", 32'(count), 32'h0);
      step(1, 1, 0, 1, 8'h55);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, W'(8'h20 + i));
      step(0, 1, 0, 0, 8'h00);
      step(0, 1, 0, 1, 8'h00);
      chk("post_reset_unf", 32'(underflow), 32'h1);
      pbias = 50;
      for (int i = 0; i < 800; i++) begin
         if (i % 40 == 0) pbias = $urandom_range(15, 85);
         step($urandom_range(0, 99) < pbias, $urandom_range(0, 99) < (100 - pbias),
              $urandom_range(0, 59) == 0, $urandom_range(0, 149) != 0, W'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stack_param.md
# stack_param

Parametrised LIFO stack, the next generation of the fixed 8x8 stack: configurable data width and depth, occupancy count, combinational top-of-stack peek, atomic replace on simultaneous push/pop, synchronous clear, and one-cycle overflow/underflow error pulses. It is intended for expression-evaluation and call-return buffering datapaths wherever the 8-entry stack was used before.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries (>=2)
- CW, $clog2(DEPTH+1), count width (derived; do not override)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (rst=0 sampled at posedge resets the block)
- push  input  1  push request
- pop  input  1  pop request
- clear  input  1  synchronous empty request; priority over push/pop
- data_in  input  WIDTH  word to push
- data_out  output  WIDTH  registered: last popped word
- top  output  WIDTH  combinational peek of current top entry; 0 when empty
- count  output  CW  current occupancy, 0..DEPTH
- empty  output  1  count==0
- full  output  1  count==DEPTH
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected
- hwm  output  CW  high-water mark (only with STACK_HWM_EN)

## Operation
- Storage: DEPTH x WIDTH register array; stack pointer = count; top = mem[count-1].
- Priority per cycle: reset > clear > push/pop.
- clear=1: count<=0; data_out holds; overflow/underflow<=0; memory not scrubbed.
- push only, not full: mem[count]<=data_in, count+1.
- push only, full: rejected, state unchanged, overflow<=1.
- pop only, not empty: data_out<=mem[count-1], count-1.
- pop only, empty: rejected, data_out holds, underflow<=1.
- push+pop, not empty (incl. full): replace: data_out<=old top, mem[count-1]<=data_in, count unchanged, no error.
- push+pop, empty: push accepted (mem[0]<=data_in, count<=1), pop rejected, underflow<=1, data_out holds.
- Neither: state holds; overflow/underflow<=0.
- empty/full derived combinationally from registered count only; never from the current-cycle request.
- All count arithmetic in CW bits; no wrap: count never leaves 0..DEPTH.

## Timing
- Reset values: data_out=0, count=0, empty=1, full=0, overflow=0, underflow=0, hwm=0, top=0.
- Push latency: entry visible on top/count one cycle after the accepting edge.
- Pop latency: data_out valid the cycle after the accepting edge; holds until next accepted pop or reset.
- overflow/underflow high exactly one cycle per rejected request; back-to-back rejections keep them high continuously.
- Reset asserted mid-operation: every output at reset value after that edge; contents discarded logically (count=0).
- No handshake beyond flags: requester must sample full/empty before issuing; rejected requests are dropped, not queued.

## Configuration
- Macro STACK_HWM_EN.
- Defined: hwm port present; register tracks max count since reset/clear; updates same edge as count (hwm<=max(hwm, next count)); clear and reset zero it.
- Undefined: hwm port and register absent; all other behaviour identical.

## Test plan
- Reset, WIDTH=8 DEPTH=8: hold rst=0 one edge -> data_out=0x00, count=0, empty=1, full=0, top=0x00.
- Push 0x03 then pop 0x03 -> after push top=0x03 count=1; after pop data_out=0x03, empty=1.
- Push 1..10 consecutively -> full=1 after 8th; pushes 9, 10 each give overflow=1 one cycle; count=8, top=0x08; then 10 pops -> data_out 8,7,...,1, then underflow pulses on pops 9, 10 with data_out held at 0x01.
- Push 0xA1, 0xB2, then push 0xC3 with pop -> data_out=0xB2, top=0xC3, count=2, no error; repeat at full -> count stays 8, overflow=0.
- Fill 5 entries, assert clear with push=1 -> count=0, empty=1, no write; hwm=5 then 0 (STACK_HWM_EN).
- Push 3 entries, rst=0 mid-stream with pop=1 -> count=0, data_out=0x00, underflow=0 next cycle; subsequent pop gives underflow=1.
